vector_address_scheduler: RTL

Parametrised vector memory address scheduler that serialises LANES per-element loads/stores from the vector unit onto the single-ported data cache interface. It generalises the two-lane scheduler to N lanes and adds several behaviours:
- SEW-aware 4-bit byte enables;
- store-data lane replication;
- per-lane misalignment detection with precise faulting-lane reporting;
- optional lane masking.

It sits between the vector load/store execute stage and the dcache request port.

---
 rtl/vector_address_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vector_address_scheduler.sv
// Serialises LANES per-element vector loads/stores onto a single-ported dcache request port.
// Optional lane masking is compiled in with `define VEC_LANE_MASK_EN.
module vector_address_scheduler #(
  parameter int LANES = 2,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  load,
  input  logic                  store,
  input  logic [LANES*32-1:0]   addr,
  input  logic [LANES*32-1:0]   storedata,
  input  logic [1:0]            sew,
  input  logic                  dhit,
  input  logic                  returnex,
`ifdef VEC_LANE_MASK_EN
  input  logic [LANES-1:0]      lane_mask,
`endif
  output logic [31:0]           final_addr,
  output logic [31:0]           final_storedata,
  output logic [3:0]            byte_ena,
  output logic                  ren,
  output logic                  wen,
  output logic [LANES-1:0]      arrived,
  output logic                  exception,
  output logic [LW-1:0]         exception_lane,
  output logic                  busy
);

  localparam logic [1:0] SEW8  = 2'd0;
  localparam logic [1:0] SEW16 = 2'd1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] EXCEPT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [LANES-1:0] arrived_q, arrived_d;
  logic [LANES-1:0] mask_q, mask_d;

  logic [31:0]      addr_q [LANES];
  logic [31:0]      data_q [LANES];
  logic [1:0]       sew_q;
  logic             op_load_q;

  logic [LANES-1:0] mask_in;
  logic             accept;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_data;
  logic             mis;
  logic [LW:0]      nxt;

  function automatic logic is_misaligned(input logic [1:0] s, input logic [1:0] a);
    case (s)
      SEW8:    return 1'b0;
      SEW16:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_byte_ena(input logic [1:0] s, input logic [1:0] a);
    case (s)
      SEW8:    return 4'b0001 << a;
      SEW16:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] s, input logic [31:0] d);
    case (s)
      SEW8:    return {4{d[7:0]}};
      SEW16:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Returns {found, index} of the lowest enabled lane at or above `from`.
  function automatic logic [LW:0] next_enabled(input logic [LANES-1:0] m, input int from);
    logic [LW:0] r;
    r = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      if (j >= from && m[j]) r = {1'b1, LW'(j)};
    end
    return r;
  endfunction

`ifdef VEC_LANE_MASK_EN
  assign mask_in = lane_mask;
`else
  assign mask_in = '1;
`endif

  assign accept   = (state_q == IDLE) && (load || store);
  assign cur_addr = addr_q[lane_q];
  assign cur_data = data_q[lane_q];
  assign mis      = is_misaligned(sew_q, cur_addr[1:0]);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    arrived_d = arrived_q;
    mask_d    = mask_q;
    nxt       = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Masked-off lanes complete at acceptance; the pointer starts on the first live lane.
          mask_d    = mask_in;
          arrived_d = ~mask_in;
          nxt       = next_enabled(mask_in, 0);
          lane_d    = nxt[LW-1:0];
          state_d   = nxt[LW] ? ACCESS : IDLE;
        end
      end
      ACCESS: begin
        if (mis) begin
          state_d = EXCEPT;
        end else if (dhit) begin
          arrived_d[lane_q] = 1'b1;
          nxt     = next_enabled(mask_q, int'(lane_q) + 1);
          lane_d  = nxt[LW-1:0];
          state_d = nxt[LW] ? ACCESS : IDLE;
        end
      end
      EXCEPT: begin
        if (returnex) begin
          state_d = IDLE;
          lane_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      arrived_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      arrived_q <= arrived_d;
      mask_q    <= mask_d;
    end
  end

  // Request payload is only consumed while ACCESS, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        addr_q[k] <= addr[k*32 +: 32];
        data_q[k] <= storedata[k*32 +: 32];
      end
      sew_q     <= sew;
      op_load_q <= load;
    end
  end

  always_comb begin
    final_addr      = '0;
    final_storedata = '0;
    byte_ena        = '0;
    ren             = 1'b0;
    wen             = 1'b0;
    if (state_q == ACCESS) begin
      final_addr      = {cur_addr[31:2], 2'b00};
      final_storedata = replicate(sew_q, cur_data);
      byte_ena        = lane_byte_ena(sew_q, cur_addr[1:0]);
      ren             = !mis && op_load_q;
      wen             = !mis && !op_load_q;
    end
  end

  assign arrived        = arrived_q;
  assign exception      = (state_q == EXCEPT);
  assign exception_lane = (state_q == EXCEPT) ? lane_q : '0;
  assign busy           = (state_q != IDLE);

endmodule
